serial_bit_subtractor: RTL

//   Bit-serial two's-complement subtractor: computes DIFF = A - B one bit per clock, LSB first,

---
 rtl/serial_bit_subtractor.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/serial_bit_subtractor.sv
// Bit-serial two's-complement subtractor (diff = a - b, LSB first, one borrow flop).
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_bit_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sd_q, sd_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             x, y, bit_d, br_nxt;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
  logic             ovf_s_q, ovf_s_d;
`endif

  assign x      = sa_q[0];
  assign y      = sb_q[0];
  assign bit_d  = x ^ y ^ br_q;
  assign br_nxt = (~x & y) | (~(x ^ y) & br_q);

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sd_d     = sd_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d    = ovf_q;
    ovf_s_d  = ovf_s_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          sd_d    = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = 1'b0;
          ovf_s_d = 1'b0;
`endif
        end
      end
      SHIFT: begin
        // One extra SHIFT cycle after the last bit publishes the result.
        if (cnt_q == CW'(WIDTH)) begin
          diff_d   = sd_q;
          borrow_d = br_q;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d    = ovf_s_q;
`endif
          state_d  = DONE;
        end else begin
          sa_d            = sa_q >> 1;
          sb_d            = sb_q >> 1;
          sd_d            = sd_q >> 1;
          sd_d[WIDTH-1]   = bit_d;
          br_d            = br_nxt;
          cnt_d           = cnt_q + CW'(1);
`ifdef SERIAL_SUB_OVF_EN
          if (cnt_q == CW'(WIDTH - 1)) ovf_s_d = br_q ^ br_nxt;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sd_q     <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
      ovf_s_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sd_q     <= sd_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= ovf_d;
      ovf_s_q  <= ovf_s_d;
`endif
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf        = ovf_q;
`endif

endmodule
